// File: rtl/vcd_pkg.sv
// Shared widths and entry layout for the value-change capture path.
// An entry is {ts, val}: val in the low bits, ts directly above it.
package vcd_pkg;

  localparam int DATA_W  = 8;
  localparam int TS_W    = 16;
  localparam int ENTRY_W = TS_W + DATA_W;

  localparam int VAL_LSB = 0;
  localparam int TS_LSB  = VAL_LSB + DATA_W;

endpackage

// File: rtl/chg_fifo.sv
// Synchronous show-ahead FIFO: the head entry is driven combinationally from
// storage at rd_ptr, and rdata reads as zero while the FIFO is empty.
module chg_fifo #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = vcd_pkg::ENTRY_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, and the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/change_logger.sv
// Logs every change of data_in as a {timestamp, value} record into a FIFO
// drained over rd_valid/rd_ready. Define CHANGE_LOGGER_DROP_CNT_EN for drop_cnt.
module change_logger #(
  parameter int DATA_W = vcd_pkg::DATA_W,
  parameter int TS_W   = vcd_pkg::TS_W,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [TS_W-1:0]   rd_ts,
  output logic [DATA_W-1:0] rd_val,
  output logic [ADDR_W:0]   level,
`ifdef CHANGE_LOGGER_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  output logic              overflow
);

  localparam int FIFO_W = TS_W + DATA_W;
  localparam int TS_POS = vcd_pkg::VAL_LSB + DATA_W;

  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] prev;
  logic              first;
  logic              evt;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic [FIFO_W-1:0] rdata;

  // The first edge after reset always logs, like a VCD initial dump.
  assign evt  = first | (data_in != prev);
  assign pop  = rd_ready & rd_valid;
  assign drop = evt & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts    <= '0;
      prev  <= '0;
      first <= 1'b1;
    end else begin
      ts    <= ts + 1'b1;
      prev  <= data_in;
      first <= 1'b0;
    end
  end

`ifdef CHANGE_LOGGER_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // drop_cnt saturates instead of wrapping, so this stays sticky.
  assign overflow = (drop_cnt != 8'h00);
`else
  logic ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`endif

  chg_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (evt),
    .wdata ({ts, data_in}),
    .pop   (rd_ready),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign rd_valid = ~empty;
  assign rd_ts    = rdata[TS_POS +: TS_W];
  assign rd_val   = rdata[vcd_pkg::VAL_LSB +: DATA_W];

endmodule

// File: doc/change_logger.md
Name: change_logger

Overview:
- Downstream consumer of the 8-bit `counter` output (`data_cnt`). Watches the sampled value and records each value change as a {timestamp, value} event in an internal FIFO.
- A host or VCD-writer stage drains the FIFO over a valid/ready interface. This gives on-chip capture of VCD-style value-change records for the prototype.

Parameters:
- DATA_W, 8, width of the monitored value.
- TS_W, 16, width of the free-running timestamp counter.
- DEPTH, 8, FIFO entries; must be a power of 2.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  monitored value (`counter.data_cnt`).
- rd_ready  input  1  consumer accepts the head entry.
- rd_valid  output  1  FIFO non-empty; head entry presented.
- rd_ts  output  TS_W  timestamp of the head entry.
- rd_val  output  DATA_W  value of the head entry.
- level  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when an event is dropped.

Behaviour:
- Reset (reset=0, async):
  - ts=0, prev=0, first=1, FIFO empty (wr_ptr=rd_ptr=0), overflow=0.
  - Outputs: rd_valid=0, rd_ts=0, rd_val=0, level=0.
- Timestamp:
  - ts increments by 1 every clk edge out of reset.
  - Wraps modulo 2^TS_W with no marker in the base build.
- Event detection at each edge:
  - event = first | (data_in != prev).
  - On that edge, prev <= data_in and first <= 0.
  - The first sampled edge after reset always logs the initial value, as a VCD initial dump does.
- Push: on event, the entry {ts, data_in} is written, using the ts value before the increment.
- Pop: on rd_valid & rd_ready, rd_ptr advances.
- Latency: the entry is visible on rd_valid/rd_ts/rd_val right after the push edge (1 cycle). The FIFO is show-ahead, so the head is driven combinationally from memory at rd_ptr.
- rd_ts and rd_val are 0 when empty.
- Full, push without pop: the event is dropped, overflow <= 1, and FIFO contents are unchanged.
- Full, push and pop on the same edge: both happen; level stays DEPTH; no drop.
- Empty, pop requested: ignored (rd_valid=0), pointers unchanged.
- level: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Pointers are ADDR_W+1 bits; full = MSBs differ and the low bits are equal.
- overflow is cleared only by reset.
- Reset mid-operation: the FIFO is flushed immediately and queued events are lost. The first edge after release logs the current data_in at ts=0.
- data_in is expected to be synchronous to clk; no synchroniser is included.

Optional Feature:
- Macro: CHANGE_LOGGER_DROP_CNT_EN.
- Defined:
  - Adds output `drop_cnt` [7:0], reset 0.
  - drop_cnt increments on every dropped event and saturates at 8'hFF.
  - overflow equals (drop_cnt != 0).
- Undefined: the port and counter are absent; overflow behaves as the sticky flag above.

Decomposition:
- Shared package `vcd_pkg` holds:
  - default widths (DATA_W=8, TS_W=16);
  - entry width localparam ENTRY_W = TS_W + DATA_W;
  - the bit-slice positions of ts/val inside an entry.
- Sub-module `chg_fifo`, a synchronous show-ahead FIFO with parameters DEPTH and ENTRY_W. Ports:
  - inputs: clk, reset, push, wdata, pop;
  - outputs: rdata, full, empty, level.
- change_logger contains the ts counter, prev/first registers, event and drop logic, and instantiates chg_fifo.

Test Plan:
- Reset release with data_in=8'h00 and rd_ready=0:
  - exactly one entry {ts=0, val=8'h00}; level=1.
  - data held constant for 20 cycles adds no entries.
- Counter load of 8'h55 via `wr` (`counter` instance driving data_in), then count 8'h55, 8'h56, 8'h57 on successive edges with rd_ready=1:
  - entries drain in order with consecutive ts values;
  - each entry's val matches data_in at its edge.
- rd_ready=0, data_in changes on 10 consecutive edges:
  - level saturates at 8; overflow=1;
  - the first 8 changes are retained in order;
  - with CHANGE_LOGGER_DROP_CNT_EN, drop_cnt=2.
- FIFO full with rd_ready=1 and a change on the same edge: level stays 8, overflow stays 0, and the new entry appears at the tail.
- ts wrap (TS_W=4), change at cycles 15 and 16: entries carry ts=4'hF then 4'h0.
- Assert reset with 5 entries queued:
  - rd_valid=0 and level=0 immediately (async);
  - after release, a new initial entry at ts=0 holds the current data_in.
